// File: rtl/bus_glue_pkg.sv
// Shared types for the 68000 bus-slave glue:
// FSM states, decoded regions and the IACK function code.
package bus_glue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_BERR
  } state_e;

  typedef enum logic [1:0] {
    RG_ROM,
    RG_RAM,
    RG_IO,
    RG_NONE
  } region_e;

  localparam logic [2:0] FC_IACK = 3'b111;

endpackage

// File: rtl/region_decode.sv
// Combinational region decode from addr[23:20] and function code.
// Flags IACK, unmapped and user-mode I/O accesses as illegal.
module region_decode
  import bus_glue_pkg::*;
#(
  parameter logic [3:0] ROM_REGION = 4'h0,
  parameter logic [3:0] RAM_REGION = 4'h1,
  parameter logic [3:0] IO_REGION  = 4'hF
) (
  input  logic [3:0] addr_hi,
  input  logic [2:0] fc,
  output region_e    region,
  output logic       illegal
);

  always_comb begin
    region = RG_NONE;
    if (addr_hi == ROM_REGION) begin
      region = RG_ROM;
    end else if (addr_hi == RAM_REGION) begin
      region = RG_RAM;
    end else if (addr_hi == IO_REGION) begin
      region = RG_IO;
    end
  end

  // fc[2] is the supervisor bit
  always_comb begin
    illegal = (fc == FC_IACK)
           || (region == RG_NONE)
           || ((region == RG_IO) && !fc[2]);
  end

endmodule

// File: rtl/bus_cycle_ctrl.sv
// 68000 bus-slave glue: region chip selects, per-region
// wait states, DTACK/BERR generation and I/O timeout.
module bus_cycle_ctrl
  import bus_glue_pkg::*;
#(
  parameter logic [3:0] ROM_REGION = 4'h0,
  parameter logic [3:0] RAM_REGION = 4'h1,
  parameter logic [3:0] IO_REGION  = 4'hF,
  parameter int         ROM_WAIT   = 2,
  parameter int         RAM_WAIT   = 0,
  parameter int         IO_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        as_n,
  input  logic        uds_n,
  input  logic        lds_n,
  input  logic        read,
  input  logic [23:0] addr,
  input  logic [2:0]  fc,
  input  logic        io_ready,
  output logic        dtack_n,
  output logic        berr_n,
  output logic        rom_cs_n,
  output logic        ram_cs_n,
  output logic        io_cs_n,
  output logic        oe_n,
  output logic        we_hi_n,
  output logic        we_lo_n
);

  localparam logic [7:0] ROM_LD = 8'(ROM_WAIT);
  localparam logic [7:0] RAM_LD = 8'(RAM_WAIT);
  localparam logic [7:0] IO_LD  = 8'(IO_TIMEOUT);

  state_e     state_q, state_d;
  region_e    region_q, region_d;
  logic       read_q, read_d;
  logic [7:0] cnt_q, cnt_d;

  region_e    dec_region;
  logic       dec_illegal;
  logic [7:0] load_val;
  logic       cs_act;
  logic       unused_addr;

  assign unused_addr = ^addr[19:0];

  region_decode #(
    .ROM_REGION (ROM_REGION),
    .RAM_REGION (RAM_REGION),
    .IO_REGION  (IO_REGION)
  ) u_dec (
    .addr_hi (addr[23:20]),
    .fc      (fc),
    .region  (dec_region),
    .illegal (dec_illegal)
  );

  always_comb begin
    unique case (dec_region)
      RG_ROM:  load_val = ROM_LD;
      RG_RAM:  load_val = RAM_LD;
      default: load_val = IO_LD;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    read_d   = read_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!as_n) begin
          region_d = dec_region;
          read_d   = read;
          if (dec_illegal) begin
            state_d = ST_BERR;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = load_val;
          end
        end
      end
      ST_WAIT: begin
        // strobe released early: abandon quietly
        if (as_n) begin
          state_d = ST_IDLE;
        end else if (region_q == RG_IO) begin
          if (io_ready) begin
            state_d = ST_ACK;
          end else if (cnt_q == 8'd1) begin
            state_d = ST_BERR;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end else if (cnt_q == 8'd0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK, ST_BERR: begin
        if (as_n) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      region_q <= RG_NONE;
      read_q   <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      read_q   <= read_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    cs_act   = (state_q == ST_WAIT) || (state_q == ST_ACK);
    dtack_n  = !(state_q == ST_ACK);
    berr_n   = !(state_q == ST_BERR);
    rom_cs_n = !(cs_act && (region_q == RG_ROM));
    ram_cs_n = !(cs_act && (region_q == RG_RAM));
    io_cs_n  = !(cs_act && (region_q == RG_IO));
    oe_n     = !(cs_act && read_q);
    we_hi_n  = !(cs_act && !read_q && !uds_n);
    we_lo_n  = !(cs_act && !read_q && !lds_n);
  end

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Randomized bus-cycle bench for bus_cycle_ctrl with a
// per-transaction timeline model of the expected pin behaviour.
module tb_bus_cycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        as_n, uds_n, lds_n, read, io_ready;
  logic [23:0] addr;
  logic [2:0]  fc;
  logic        dtack_n, berr_n, rom_cs_n, ram_cs_n, io_cs_n;
  logic        oe_n, we_hi_n, we_lo_n;
  logic [7:0]  outs;

  int vectors = 0;
  int miscompares = 0;
  int txn_no = 0;

  always #5 clk = ~clk;

  bus_cycle_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .as_n     (as_n),
    .uds_n    (uds_n),
    .lds_n    (lds_n),
    .read     (read),
    .addr     (addr),
    .fc       (fc),
    .io_ready (io_ready),
    .dtack_n  (dtack_n),
    .berr_n   (berr_n),
    .rom_cs_n (rom_cs_n),
    .ram_cs_n (ram_cs_n),
    .io_cs_n  (io_cs_n),
    .oe_n     (oe_n),
    .we_hi_n  (we_hi_n),
    .we_lo_n  (we_lo_n)
  );

  assign outs = {dtack_n, berr_n, rom_cs_n, ram_cs_n,
                 io_cs_n, oe_n, we_hi_n, we_lo_n};

  task automatic check_eq(string tag, logic [7:0] got,
                          logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // phase: 0 idle, 1 waiting, 2 acknowledged, 3 bus error
  function automatic logic [7:0] model_out(int phase, int rg,
    logic rd, logic u, logic l);
    logic sel;
    sel = (phase == 1) || (phase == 2);
    return {phase != 2, phase != 3,
            !(sel && rg == 0), !(sel && rg == 1),
            !(sel && rg == 2), !(sel && rd),
            !(sel && !rd && !u), !(sel && !rd && !l)};
  endfunction

  // iod: edge (1 = first WAIT edge) at which io_ready is high
  // abort_at: edge at which as_n is seen high (0 = no abort)
  task automatic run_txn(logic [23:0] a, logic [2:0] f,
    logic rd, logic u, logic l, int iod, int abort_at,
    int hold);
    int  rg, resp, rel, phase;
    bit  illegal, to_berr;
    logic [3:0] nib;
    nib = a[23:20];
    rg = (nib == 4'h0) ? 0 : (nib == 4'h1) ? 1 :
         (nib == 4'hF) ? 2 : 3;
    illegal = (f == 3'b111) || (rg == 3) ||
              (rg == 2 && !f[2]);
    to_berr = 0;
    if (illegal) begin
      resp = 0;
    end else if (rg == 0) begin
      resp = 1 + 2;
    end else if (rg == 1) begin
      resp = 1 + 0;
    end else if (iod <= 64) begin
      resp = iod;
    end else begin
      resp = 64;
      to_berr = 1;
    end
    if (!illegal && abort_at >= 1 && abort_at <= resp)
      rel = abort_at;
    else
      rel = resp + 1 + hold;
    addr = a; fc = f; read = rd; uds_n = u; lds_n = l;
    as_n = 1'b0;
    io_ready = (rg == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    for (int k = 0; k <= rel; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k >= rel) phase = 0;
      else if (illegal) phase = 3;
      else if (k < resp) phase = 1;
      else if (to_berr) phase = 3;
      else phase = 2;
      check_eq($sformatf("txn%0d_e%0d", txn_no, k), outs,
               model_out(phase, rg, rd, u, l));
      as_n = (k + 1 >= rel);
      if (rg == 2) io_ready = (k + 1 >= iod);
      else io_ready = 1'($urandom_range(0, 1));
    end
    as_n = 1'b1;
    io_ready = 1'b0;
    txn_no++;
  endtask

  task automatic idle_gap(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      uds_n = 1'($urandom_range(0, 1));
      lds_n = 1'($urandom_range(0, 1));
      addr = 24'($urandom);
      #1;
      check_eq("idle", outs, 8'hFF);
    end
  endtask

  initial begin
    logic [23:0] a;
    logic [2:0]  f;
    logic [3:0]  nib;
    logic [2:0]  fc_tbl [5];
    int          iod, ab, sel_rg;
    logic        u, l;
    fc_tbl = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b111};

    reset = 1'b0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    read = 1'b1; addr = '0; fc = 3'b110; io_ready = 1'b0;
    #1 reset = 1'b1;
    #2 check_eq("reset_async", outs, 8'hFF);
    repeat (3) @(negedge clk);
    check_eq("reset_hold", outs, 8'hFF);
    reset = 1'b0;
    idle_gap(2);

    run_txn(24'h000100, 3'b110, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    run_txn(24'h100000, 3'b101, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    run_txn(24'h100002, 3'b101, 1'b0, 1'b1, 1'b0, 0, 0, 2);
    run_txn(24'hF00000, 3'b101, 1'b1, 1'b0, 1'b0, 5, 0, 1);
    run_txn(24'hF00000, 3'b001, 1'b1, 1'b0, 1'b0, 5, 0, 1);
    run_txn(24'h500000, 3'b110, 1'b1, 1'b0, 1'b0, 0, 0, 1);
    run_txn(24'hF00010, 3'b110, 1'b1, 1'b0, 1'b0, 1000, 0, 1);
    run_txn(24'h000200, 3'b110, 1'b1, 1'b0, 1'b0, 0, 2, 0);
    run_txn(24'h000000, 3'b111, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    run_txn(24'hF00004, 3'b101, 1'b0, 1'b0, 1'b1, 64, 0, 0);
    run_txn(24'hF00004, 3'b101, 1'b1, 1'b0, 1'b0, 65, 0, 0);
    run_txn(24'hF00006, 3'b101, 1'b1, 1'b0, 1'b0, 1, 0, 0);
    idle_gap(1);

    // reset pulse while DTACK is asserted, as_n held low
    addr = 24'h000100; fc = 3'b110; read = 1'b1;
    uds_n = 1'b0; lds_n = 1'b0; as_n = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("rst_pre_ack", outs, 8'b0101_1011);
    #2 reset = 1'b1;
    #1 check_eq("rst_mid_ack", outs, 8'hFF);
    #1 reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("rst_new_e%0d", k), outs,
               (k < 3) ? 8'b1101_1011 : 8'b0101_1011);
    end
    as_n = 1'b1;
    @(negedge clk);
    check_eq("rst_release", outs, 8'hFF);

    for (int t = 0; t < 150; t++) begin
      sel_rg = $urandom_range(0, 3);
      nib = (sel_rg == 0) ? 4'h0 : (sel_rg == 1) ? 4'h1 :
            (sel_rg == 2) ? 4'hF : 4'($urandom_range(2, 14));
      a = {nib, 20'($urandom)};
      f = fc_tbl[$urandom_range(0, 4)];
      u = 1'($urandom_range(0, 1));
      l = u ? 1'b0 : 1'($urandom_range(0, 1));
      iod = ($urandom_range(0, 7) == 0) ? 1000 :
            $urandom_range(1, 12);
      ab = ($urandom_range(0, 4) == 0) ?
           $urandom_range(1, 3) : 0;
      run_txn(a, f, 1'($urandom_range(0, 1)), u, l, iod, ab,
              $urandom_range(0, 2));
      idle_gap($urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
